// File: rtl/pb_debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
// Provides the FSM state type and the default/simulation qualification lengths.
package pb_debounce_pkg;

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      IDLE_HIGH = 2'd2,
      WAIT_LOW  = 2'd3
   } db_state_t;

   localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
   localparam int DEBOUNCE_CYCLES_SIM     = 4;

   // Timer width that never collapses to zero bits.
   function automatic int db_cnt_w(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for inputs asynchronous to clk.
// Ports: clk, reset (async, active-high, clears to 0), d_in (async), d_out (synchronized).
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d_in,
   output logic d_out
);

   logic s1_q;
   logic s1_d;
   logic s2_q;
   logic s2_d;

   always_comb begin
      s1_d = d_in;
      s2_d = s1_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign d_out = s2_q;

endmodule

// File: rtl/pb_debouncer.sv
// Push-button debouncer: synchronizer, qualification timer and 4-state FSM.
// Ports: clk, reset (async, active-high), btn_in (raw, async, bouncing),
//        btn_level (debounced level), btn_pulse / btn_release_pulse (1-cycle strobes).
module pb_debouncer
   import pb_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int CNT_W           = db_cnt_w(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_pulse,
   output logic btn_release_pulse
);

   localparam logic [CNT_W-1:0] TMR_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMR_ZERO = '0;
   localparam logic [CNT_W-1:0] TMR_ONE  = CNT_W'(1);

   logic      btn_s2;
   db_state_t state_q;
   db_state_t state_d;
   logic [CNT_W-1:0] timer_q;
   logic [CNT_W-1:0] timer_d;
   logic      level_q;
   logic      level_d;
   logic      pulse_q;
   logic      pulse_d;
   logic      rel_q;
   logic      rel_d;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d_in  (btn_in),
      .d_out (btn_s2)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE_LOW;
         timer_q <= TMR_ZERO;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         level_q <= level_d;
         pulse_q <= pulse_d;
         rel_q   <= rel_d;
      end
   end

   // Strobes default low so they last exactly one cycle.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      level_d = level_q;
      pulse_d = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
         IDLE_LOW: begin
            if (btn_s2) begin
               state_d = WAIT_HIGH;
               timer_d = TMR_ZERO;
            end
         end
         WAIT_HIGH: begin
            if (!btn_s2) begin
               state_d = IDLE_LOW;
               timer_d = TMR_ZERO;
            end else if (timer_q == TMR_LAST) begin
               state_d = IDLE_HIGH;
               timer_d = TMR_ZERO;
               level_d = 1'b1;
               pulse_d = 1'b1;
            end else begin
               timer_d = timer_q + TMR_ONE;
            end
         end
         IDLE_HIGH: begin
            if (!btn_s2) begin
               state_d = WAIT_LOW;
               timer_d = TMR_ZERO;
            end
         end
         WAIT_LOW: begin
            if (btn_s2) begin
               state_d = IDLE_HIGH;
               timer_d = TMR_ZERO;
            end else if (timer_q == TMR_LAST) begin
               state_d = IDLE_LOW;
               timer_d = TMR_ZERO;
               level_d = 1'b0;
               rel_d   = 1'b1;
            end else begin
               timer_d = timer_q + TMR_ONE;
            end
         end
         default: begin
            state_d = IDLE_LOW;
            timer_d = TMR_ZERO;
            level_d = 1'b0;
         end
      endcase
   end

   assign btn_level         = level_q;
   assign btn_pulse         = pulse_q;
   assign btn_release_pulse = rel_q;

endmodule
